// File: rtl/core2_arbiter_if.sv
// Bundles the core2_arbiter buses: both requester channels, the Core2
// issue/result channel, the response channel and the busy flag.
// slave  : the arbiter side.
// master : the environment side (requesters, Core2 and response consumer).
interface core2_arbiter_if #(
    parameter int DATA_W = 128
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [2:0]            req0_cmd;
    logic [DATA_W-1:0]     req0_a;
    logic [DATA_W-1:0]     req0_b;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [2:0]            req1_cmd;
    logic [DATA_W-1:0]     req1_a;
    logic [DATA_W-1:0]     req1_b;

    logic                  core_start;
    logic [2:0]            core_sel;
    logic [DATA_W-1:0]     core_a;
    logic [DATA_W-1:0]     core_b;
    logic                  core_done;
    logic [2*DATA_W-1:0]   core_result;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [2*DATA_W-1:0]   rsp_data;
    logic                  rsp_err;
    logic                  busy;

    modport slave (
        input  req0_valid, req0_cmd, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_cmd, req1_a, req1_b,
        output req1_ready,
        output core_start, core_sel, core_a, core_b,
        input  core_done, core_result,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_cmd, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_cmd, req1_a, req1_b,
        input  req1_ready,
        input  core_start, core_sel, core_a, core_b,
        output core_done, core_result,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/core2_arbiter.sv
// core2_arbiter: round-robin arbiter/sequencer sharing one Core2 field
// arithmetic unit between two requesters. One operation in flight at a time:
// IDLE (accept) -> ISSUE (start pulse) -> WAIT (Core2 done) -> RESP (handshake).
// Optional watchdog on the WAIT state: define CORE2_ARB_TIMEOUT_EN to enable it;
// without it WAIT lasts until core_done and rsp_err is always 0.
module core2_arbiter #(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    core2_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   grant;
    logic   accept;
    logic   timed_out;

    // Pick the requester for this cycle and decode the ready strobes
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
        bus.req0_ready = (state == IDLE) && !grant && bus.req0_valid;
        bus.req1_ready = (state == IDLE) &&  grant && bus.req1_valid;
        accept         = bus.req0_ready || bus.req1_ready;
    end

`ifdef CORE2_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Watchdog counter: zero on the first WAIT cycle, +1 every WAIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT-th WAIT cycle; core_done in that cycle still wins
    always_comb begin
        timed_out = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
    end
`else
    // No watchdog: WAIT only ends on core_done
    always_comb begin
        timed_out = 1'b0;
    end
`endif

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = ISSUE;
                else        state_next = IDLE;
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.core_done || timed_out) state_next = RESP;
                else                            state_next = WAIT;
            end
            RESP: begin
                if (bus.rsp_ready) state_next = IDLE;
                else               state_next = RESP;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; control outputs are registered copies of the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.core_start <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_next;
            bus.core_start <= (state_next == ISSUE);
            bus.rsp_valid  <= (state_next == RESP);
            bus.busy       <= (state_next != IDLE);
        end
    end

    // Latch the granted payload and owner, and remember who won for the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            bus.core_sel <= 3'd0;
            bus.core_a   <= '0;
            bus.core_b   <= '0;
            bus.rsp_id   <= 1'b0;
        end else if (accept) begin
            if (grant) begin
                bus.core_sel <= bus.req1_cmd;
                bus.core_a   <= bus.req1_a;
                bus.core_b   <= bus.req1_b;
            end else begin
                bus.core_sel <= bus.req0_cmd;
                bus.core_a   <= bus.req0_a;
                bus.core_b   <= bus.req0_b;
            end
            last_grant <= grant;
            bus.rsp_id <= grant;
        end
    end

    // Capture the Core2 result (or the timeout marker); done outside WAIT is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
        end else if ((state == WAIT) && bus.core_done) begin
            bus.rsp_data <= bus.core_result;
            bus.rsp_err  <= 1'b0;
        end else if (timed_out) begin
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b1;
        end
    end

endmodule

// File: doc/core2_arbiter.md
# core2_arbiter

Round-robin arbiter and sequencer that shares a single Core2 field-arithmetic unit between two independent requesters, e.g. the point-add and point-double sequencers. Each requester hands over one operation: a 3-bit select code plus two 128-bit operands. The arbiter grants one requester, issues the operation to Core2 with a start pulse, waits for Core2's done, and returns the 256-bit result tagged with the requester ID. The block sits between the requester state machines and the Core2 instance and replaces direct FIFO-driven access to Core2.

## Interface
Parameters:
- DATA_W, 128, operand width; result width is 2*DATA_W.
- TIMEOUT, 1024, watchdog limit in cycles; used only with CORE2_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester N presents an operation.
- req0_ready / req1_ready  out  1  arbiter accepts requester N this cycle.
- req0_cmd / req1_cmd  in  3  Core2 select code.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands.
- core_start  out  1  one-cycle issue pulse to Core2.
- core_sel  out  3  latched select code, stable from issue until result capture.
- core_a, core_b  out  DATA_W  latched operands, stable over the same window.
- core_done  in  1  Core2 result valid, single-cycle pulse.
- core_result  in  2*DATA_W  Core2 result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  2*DATA_W  captured result.
- rsp_err  out  1  timeout flag; constant 0 without the macro.
- busy  out  1  high in every state except IDLE.

## Operation
- Four-state FSM:
  - IDLE: accept a request.
  - ISSUE: one cycle.
  - WAIT: wait for Core2.
  - RESP: hold the response until the handshake.
- Grant in IDLE:
  - Only one valid request: that requester is granted.
  - Both valid: grant the requester opposite last_grant.
  - last_grant resets to 1, so req0 wins the first tie.
- reqN_ready is combinational: (state==IDLE) && grant==N && reqN_valid. Never both high in the same cycle.
- Transfer on valid&ready:
  - Latch cmd, a, b and the requester ID.
  - Update last_grant.
  - Go to ISSUE.
- ISSUE: core_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - core_done is sampled only in this state.
  - On core_done: capture core_result into rsp_data, clear rsp_err, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_err held stable.
  - On rsp_ready: go to IDLE.
- core_done outside WAIT is ignored.
- Requests arriving while busy wait; the requester must hold valid and its payload stable until ready.

## Timing
- Reset values:
  - State IDLE.
  - core_start, rsp_valid, rsp_err, busy = 0.
  - core_sel, core_a, core_b, rsp_id, rsp_data = 0.
  - last_grant = 1.
- Accept at cycle T:
  - core_start high in T+1.
  - Earliest core_done sampled in T+2.
  - rsp_valid high from T+3.
- Response handshake at cycle R: state is IDLE at R+1, and a new accept can occur in R+1.
- Minimum spacing between accepts: 4 cycles.
- Reset mid-operation:
  - Returns to IDLE next cycle and drops the in-flight operation with no response.
  - A late core_done after reset is ignored.
- Starvation bound: with both requesters valid continuously, grants alternate 0,1,0,1.

## Configuration
- CORE2_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without core_done: go to RESP with rsp_err=1 and rsp_data=0.
  - core_done in the same cycle the counter reaches TIMEOUT wins: normal response, rsp_err=0.
- Undefined:
  - No counter; WAIT lasts indefinitely.
  - rsp_err is tied 0.

## Test plan
- Single op: req0 cmd=3, a=5, b=7; Core2 model returns 0x23 after 4 cycles → core_start once at T+1; rsp_valid with rsp_id=0, rsp_data=0x23, rsp_err=0.
- Tie: req0 and req1 valid from reset → grant order 0,1,0,1 over four ops; each core_sel/core_a/core_b matches the granted requester's payload.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP → rsp_valid, rsp_id and rsp_data stable; no core_start; req1 not accepted until the cycle after the handshake.
- Spurious done: pulse core_done in IDLE and in ISSUE → ignored; the result is captured only from the WAIT-state pulse.
- Reset in WAIT: assert rst for 1 cycle, then deliver core_done → all outputs at reset values; no rsp_valid.
- Timeout (macro on, TIMEOUT=16): Core2 never responds → rsp_valid at WAIT entry+16 cycles with rsp_err=1, rsp_data=0. Repeat with core_done exactly at cycle 16 → rsp_err=0.
